// File: rtl/rolling_stats_pkg.sv
// Shared widths, defaults and FSM encoding for the rolling statistics producer.
package rolling_stats_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_WINDOW = 20;

   function automatic int sum_w(input int dw, input int win);
      return dw + $clog2(win);
   endfunction

   function automatic int sq_w(input int dw, input int win);
      return 2 * dw + $clog2(win);
   endfunction

   typedef enum logic [1:0] {
      IDLE,
      DIV_SUM,
      DIV_SQ,
      OUT
   } state_t;

endpackage

// File: rtl/rolling_stats_producer_seq_divider.sv
// Restoring divider, one quotient bit per cycle; a shorter iteration count
// divides a zero-extended narrower dividend held in the low bits.
module seq_divider #(
   parameter int W    = 21,
   parameter int QW   = 16,
   parameter int DV_W = 5,
   parameter int CW   = $clog2(W + 1)
) (
   input  logic            clk,
   input  logic            i_rst_n,
   input  logic            i_abort,
   input  logic            i_start,
   input  logic [W-1:0]    i_dividend,
   input  logic [DV_W-1:0] i_divisor,
   input  logic [CW-1:0]   i_iters,
   output logic            o_busy,
   output logic            o_done,
   output logic [QW-1:0]   o_quotient
);

   logic [W-1:0]    r_dvd;
   logic [DV_W-1:0] r_rem;
   logic [DV_W-1:0] r_divisor;
   logic [QW-2:0]   r_quo;
   logic [CW-1:0]   r_cnt;
   logic            r_busy;

   logic [DV_W:0]   w_trial;
   logic            w_ge;
   logic [CW-1:0]   w_shift;

   assign w_trial    = {r_rem, r_dvd[W-1]};
   assign w_ge       = (w_trial >= {1'b0, r_divisor});
   assign w_shift    = CW'(W) - i_iters;
   assign o_quotient = {r_quo, w_ge};
   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_cnt == CW'(1));

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_busy    <= 1'b0;
         r_cnt     <= '0;
         r_dvd     <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_quo     <= '0;
      end else if (i_abort) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
      end else if (i_start) begin
         // Align the meaningful dividend bits to the MSB end.
         r_busy    <= 1'b1;
         r_cnt     <= i_iters;
         r_dvd     <= i_dividend << w_shift;
         r_rem     <= '0;
         r_divisor <= i_divisor;
         r_quo     <= '0;
      end else if (r_busy) begin
         if (w_ge) begin
            r_rem <= DV_W'(w_trial - {1'b0, r_divisor});
         end else begin
            r_rem <= DV_W'(w_trial);
         end
         r_dvd <= {r_dvd[W-2:0], 1'b0};
         r_quo <= o_quotient[QW-2:0];
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rolling_stats_producer.sv
// Windowed sum / sum-of-squares producer with mean and square-mean output.
// ROLLING_STATS_WARMUP_EN: emit statistics over the partial window during fill.
module rolling_stats_producer
   import rolling_stats_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int WINDOW = DEF_WINDOW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          mean,
   output logic [2*DATA_W-1:0]        sqr_mean,
   output logic [DATA_W-1:0]          current_data,
   output logic [$clog2(WINDOW+1)-1:0] fill
);

   localparam int SUM_W  = sum_w(DATA_W, WINDOW);
   localparam int SQ_W   = sq_w(DATA_W, WINDOW);
   localparam int FILL_W = $clog2(WINDOW + 1);
   localparam int PTR_W  = $clog2(WINDOW);
   localparam int CNT_W  = $clog2(SQ_W + 1);
   localparam int QW     = 2 * DATA_W;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [DATA_W-1:0]   r_buf [WINDOW];
   logic [PTR_W-1:0]    r_ptr;
   logic [FILL_W-1:0]   r_fill;
   logic [SUM_W-1:0]    r_sum;
   logic [SQ_W-1:0]     r_sumsq;
   logic [DATA_W-1:0]   r_mean;
   logic [DATA_W-1:0]   r_mean_q;
   logic [QW-1:0]       r_sqr;
   logic [DATA_W-1:0]   r_cur;

   logic                w_accept;
   logic                w_full;
   logic                w_go_div;
   logic [DATA_W-1:0]   w_old;
   logic [SUM_W-1:0]    w_sum_nxt;
   logic [SQ_W-1:0]     w_sumsq_nxt;
   logic [FILL_W-1:0]   w_fill_nxt;
   logic [PTR_W-1:0]    w_ptr_nxt;
   logic [FILL_W-1:0]   w_divisor;

   logic                w_div_start;
   logic                w_div_busy;
   logic                w_div_done;
   logic [SQ_W-1:0]     w_div_dividend;
   logic [CNT_W-1:0]    w_div_iters;
   logic [QW-1:0]       w_div_quo;

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == OUT);
   assign mean         = r_mean;
   assign sqr_mean     = r_sqr;
   assign current_data = r_cur;
   assign fill         = r_fill;

   assign w_accept = in_valid && (r_state == IDLE) && !clr;
   assign w_full   = (r_fill == FILL_W'(WINDOW));
   assign w_old    = r_buf[r_ptr];

   assign w_fill_nxt = w_full ? r_fill : r_fill + FILL_W'(1);
   assign w_ptr_nxt  = (r_ptr == PTR_W'(WINDOW - 1)) ? '0
                                                     : r_ptr + PTR_W'(1);

   // Add and evict in the same edge so the sums never exceed a full window.
   assign w_sum_nxt = r_sum + SUM_W'(in_data)
                    - (w_full ? SUM_W'(w_old) : '0);
   assign w_sumsq_nxt = r_sumsq
                      + SQ_W'(in_data) * SQ_W'(in_data)
                      - (w_full ? SQ_W'(w_old) * SQ_W'(w_old) : '0);

`ifdef ROLLING_STATS_WARMUP_EN
   assign w_go_div  = 1'b1;
   assign w_divisor = (r_state == IDLE) ? w_fill_nxt : r_fill;
`else
   assign w_go_div  = (w_fill_nxt == FILL_W'(WINDOW));
   assign w_divisor = FILL_W'(WINDOW);
`endif

   assign w_div_start = (w_accept && w_go_div)
                     || (r_state == DIV_SUM && w_div_done && !clr);
   assign w_div_dividend = (r_state == IDLE) ? SQ_W'(w_sum_nxt) : r_sumsq;
   assign w_div_iters    = (r_state == IDLE) ? CNT_W'(SUM_W)
                                             : CNT_W'(SQ_W);

   seq_divider #(
      .W    (SQ_W),
      .QW   (QW),
      .DV_W (FILL_W),
      .CW   (CNT_W)
   ) u_div (
      .clk        (clk),
      .i_rst_n    (rst),
      .i_abort    (clr),
      .i_start    (w_div_start),
      .i_dividend (w_div_dividend),
      .i_divisor  (w_divisor),
      .i_iters    (w_div_iters),
      .o_busy     (w_div_busy),
      .o_done     (w_div_done),
      .o_quotient (w_div_quo)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (in_valid && w_go_div) w_state_nxt = DIV_SUM;
         end
         DIV_SUM: begin
            if (w_div_busy && w_div_done) w_state_nxt = DIV_SQ;
         end
         DIV_SQ: begin
            if (w_div_busy && w_div_done) w_state_nxt = OUT;
         end
         OUT: begin
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (clr) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_buf[r_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr    <= '0;
         r_fill   <= '0;
         r_sum    <= '0;
         r_sumsq  <= '0;
         r_mean   <= '0;
         r_mean_q <= '0;
         r_sqr    <= '0;
         r_cur    <= '0;
      end else if (clr) begin
         r_ptr   <= '0;
         r_fill  <= '0;
         r_sum   <= '0;
         r_sumsq <= '0;
      end else begin
         if (w_accept) begin
            r_ptr   <= w_ptr_nxt;
            r_fill  <= w_fill_nxt;
            r_sum   <= w_sum_nxt;
            r_sumsq <= w_sumsq_nxt;
            r_cur   <= in_data;
         end
         if (r_state == DIV_SUM && w_div_done) begin
            r_mean_q <= w_div_quo[DATA_W-1:0];
         end
         // Publish both results together so the pair is always coherent.
         if (r_state == DIV_SQ && w_div_done) begin
            r_mean <= r_mean_q;
            r_sqr  <= w_div_quo;
         end
      end
   end

endmodule

// File: tb/tb_rolling_stats_producer.sv
// Scoreboard bench for rolling_stats_producer (default build, WINDOW=20).
module tb_rolling_stats_producer;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  mean;
   logic [15:0] sqr_mean;
   logic [7:0]  current_data;
   logic [4:0]  fill;

   typedef struct {
      logic [7:0]  m;
      logic [15:0] s;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   time  t_acc = 0;
   logic prev_ov = 1'b0;

   always #5 clk = ~clk;

   rolling_stats_producer dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .mean         (mean),
      .sqr_mean     (sqr_mean),
      .current_data (current_data),
      .fill         (fill)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1 && out_valid === 1'b1 && prev_ov !== 1'b1) begin
         chk("latency", 32'(($time - 5 - t_acc) / 10), 34);
      end
      if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            fail_now("unexpected_output");
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("mean", 32'(mean), 32'(e.m));
            chk("sqr_mean", 32'(sqr_mean), 32'(e.s));
         end
      end
      prev_ov = out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int m, input int s);
      exp_t e;
      e.m = 8'(m);
      e.s = 16'(s);
      q.push_back(e);
   endtask

   task automatic send(input int d);
      int k = 0;
      while (!in_ready && k < 200) begin
         tick();
         k++;
      end
      if (!in_ready) begin
         fail_now("send_timeout");
      end else begin
         in_valid = 1'b1;
         in_data  = 8'(d);
         @(posedge clk);
         t_acc = $time;
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int k = 0;
      while ((q.size() != 0 || !in_ready) && k < 300) begin
         tick();
         k++;
      end
      if (q.size() != 0 || !in_ready) fail_now("drain_timeout");
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   initial begin
      rst       = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) tick();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_fill", 32'(fill), 0);
      chk("rst_mean", 32'(mean), 0);
      chk("rst_sqr_mean", 32'(sqr_mean), 0);
      chk("rst_current", 32'(current_data), 0);
      rst = 1'b1;
      tick();

      // Flat window
      for (int i = 0; i < 19; i++) send(10);
      tick();
      chk("flat_fill19", 32'(fill), 19);
      chk("flat_no_out", 32'(out_valid), 0);
      push(10, 100);
      send(10);
      drain();
      chk("flat_fill20", 32'(fill), 20);
      chk("flat_current", 32'(current_data), 10);

      // Ramp and oldest-sample eviction
      do_clr();
      chk("clr_fill", 32'(fill), 0);
      for (int i = 1; i < 20; i++) send(i);
      push(10, 143);
      send(20);
      drain();
      push(11, 165);
      send(21);
      drain();

      // Extremes, then decay to zero
      do_clr();
      for (int i = 0; i < 19; i++) send(255);
      push(255, 65025);
      send(255);
      drain();
      for (int k = 1; k <= 20; k++) begin
         push((255 * (20 - k)) / 20, (65025 * (20 - k)) / 20);
         send(0);
         drain();
      end

      // Backpressure: 19 x 3 then 43 -> sum 100, sumsq 2020
      do_clr();
      for (int i = 0; i < 19; i++) send(3);
      push(5, 101);
      out_ready = 1'b0;
      send(43);
      begin
         int k = 0;
         while (!out_valid && k < 100) begin
            tick();
            k++;
         end
      end
      if (!out_valid) fail_now("bp_wait_valid");
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 8'd99;
         tick();
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_mean", 32'(mean), 5);
         chk("bp_sqr_mean", 32'(sqr_mean), 101);
         chk("bp_current", 32'(current_data), 43);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_valid_drop", 32'(out_valid), 0);
      chk("bp_in_ready_back", 32'(in_ready), 1);
      chk("bp_fill", 32'(fill), 20);

      // Warm-up then flush with a colliding sample
      do_clr();
      for (int i = 0; i < 19; i++) send(5);
      tick();
      chk("warm_fill19", 32'(fill), 19);
      chk("warm_no_out", 32'(out_valid), 0);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'd200;
      tick();
      clr      = 1'b0;
      in_valid = 1'b0;
      chk("flush_fill", 32'(fill), 0);
      chk("flush_dropped", 32'(current_data), 5);
      for (int i = 0; i < 19; i++) send(7);
      push(7, 49);
      send(7);
      drain();

      // Reset in the middle of the sum divide
      do_clr();
      for (int i = 0; i < 20; i++) send(9);
      repeat (10) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid_out_valid", 32'(out_valid), 0);
      chk("mid_fill", 32'(fill), 0);
      chk("mid_mean", 32'(mean), 0);
      chk("mid_sqr_mean", 32'(sqr_mean), 0);
      chk("mid_in_ready", 32'(in_ready), 1);
      chk("mid_current", 32'(current_data), 0);
      repeat (60) tick();
      chk("mid_no_stale", 32'(out_valid), 0);
      chk("queue_empty", 32'(q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rolling_stats_producer.md
Name: rolling_stats_producer

Overview:
- Producer side of the windowed-statistics interface that the z-score trade logic consumes.
- Accepts a stream of price samples and keeps a circular window of the last WINDOW samples.
- Maintains the running sum and the running sum of squares over that window.
- Emits a registered mean / square-mean pair with a valid/ready handshake; the downstream computes variance = sqr_mean - mean*mean.

Parameters:
DATA_W, 8, sample width; the mean output has this width
WINDOW, 20, window length in samples; must be >= 2; need not be a power of two

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
clr  input  1  synchronous window flush, active-high
in_valid  input  1  sample valid
in_ready  output  1  block can accept a sample
in_data  input  DATA_W  unsigned price sample
out_valid  output  1  statistics valid
out_ready  input  1  downstream accepts statistics
mean  output  DATA_W  floor(sum / WINDOW)
sqr_mean  output  2*DATA_W  floor(sum of squares / WINDOW)
current_data  output  DATA_W  most recently accepted sample
fill  output  clog2(WINDOW+1)  number of valid samples in the window, saturating at WINDOW

Behaviour:
- Widths: SUM_W = DATA_W + clog2(WINDOW), i.e. 13 at defaults. SQ_W = 2*DATA_W + clog2(WINDOW), i.e. 21 at defaults. All arithmetic is unsigned with no truncation before the divide.
- Reset (rst=0 at a clock edge): state IDLE, buffer write pointer 0, fill 0, both sums 0, out_valid 0, mean 0, sqr_mean 0, current_data 0. Buffer contents need not be cleared, because fill gates their use.
- FSM states: IDLE, DIV_SUM, DIV_SQ, OUT.
- in_ready = 1 only in IDLE.
- Accept edge (in_valid && in_ready):
  - Write the sample at the write pointer, wrapping at WINDOW-1 back to 0.
  - current_data <= in_data.
  - If fill == WINDOW, subtract the overwritten sample from sum and its square from sumsq, in the same edge as the add.
  - fill increments, saturating at WINDOW.
- Transition after an accept:
  - If the updated fill < WINDOW (warm-up), return to IDLE with no output.
  - Otherwise go to DIV_SUM.
- Division: a restoring divider with constant divisor WINDOW produces one quotient bit per cycle.
  - DIV_SUM lasts SUM_W cycles and divides sum.
  - DIV_SQ lasts SQ_W cycles and divides sumsq.
  - The results load into mean and sqr_mean on the final DIV_SQ edge.
- OUT: out_valid rises exactly SUM_W+SQ_W cycles after the accept edge (34 at defaults).
  - mean and sqr_mean stay stable while out_valid=1 and out_ready=0.
  - On an edge with out_valid && out_ready: out_valid drops and the state returns to IDLE. The next sample can be accepted on the following edge.
- out_valid never changes while waiting for out_ready.
- clr (sync, active-high), honoured in any state:
  - Resets fill, pointer and both sums; drops out_valid; returns to IDLE.
  - Any in-progress divide is abandoned.
  - clr has priority over a simultaneous accept, and that sample is dropped.
  - mean, sqr_mean and current_data retain their last values.
- Reset mid-divide: the divide is abandoned and all reset values apply on the next edge.
- Saturation cannot occur: mean <= 2^DATA_W - 1 and sqr_mean <= (2^DATA_W - 1)^2 by construction.

Optional Feature:
- Macro: ROLLING_STATS_WARMUP_EN.
- Defined: during warm-up every accept still enters DIV_SUM, and the divisor is the updated fill (1..WINDOW) instead of WINDOW. The divider therefore takes a variable divisor input.
  - Example: the first sample 50 yields mean 50, sqr_mean 2500.
- Undefined: no output until fill == WINDOW; the divisor is the constant WINDOW.
- Latency is SUM_W+SQ_W in both builds.

Decomposition:
- Package rolling_stats_pkg holds:
  - DATA_W and WINDOW defaults.
  - The derived SUM_W and SQ_W width functions, built on clog2.
  - The state enum typedef (IDLE, DIV_SUM, DIV_SQ, OUT).
- Sub-module seq_divider is shared for both divides.
  - Parameterised dividend width; inputs start, dividend and divisor; outputs busy, done and quotient.
  - Restoring algorithm, one bit per cycle.
  - Instantiated once and reused with the dividend width SQ_W; for the sum divide, the sum is zero-extended and the iteration count is SUM_W.

Test Plan:
- Flat window: 20 samples of 10, out_ready=1 -> exactly one out_valid, on sample 20, with mean=10 and sqr_mean=100; out_valid rises 34 cycles after the 20th accept.
- Ramp: samples 1..20 -> mean=10 (210/20) and sqr_mean=143 (2870/20). Then push 21 -> mean=11 (230/20) and sqr_mean=165 (3310/20), proving the oldest-sample subtract.
- Extremes: 20 samples of 255 -> mean=255, sqr_mean=65025; then 20 samples of 0 -> mean=0, sqr_mean=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, in_valid ignored. Raise out_ready -> one transfer, then in_ready=1 on the next cycle.
- Warm-up and flush (macro undefined): 19 samples -> no out_valid and fill=19. Then assert clr together with in_valid -> fill=0 and the sample is dropped; a further 20 samples of 7 -> mean=7, sqr_mean=49.
- Reset mid-divide: assert rst=0 for one edge 10 cycles into DIV_SUM -> out_valid=0, fill=0, mean=0 and in_ready=1 after release; no stale output is ever produced.
